write_back_stage: RTL and testbench

//  Final pipeline stage: the MEM/WB pipeline register plus write-back mux and the sole driver of the register file write port.

---
 rtl/write_back_stage.sv | 120 ++++++++++++
 tb/tb_write_back_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_stage.sv
// write_back_stage: MEM/WB pipeline register, write-back data mux and the
// register file write port driver, plus a retired-instruction counter.
// Optional feature macro: WB_R15_REDIRECT_EN
//   defined   : a valid write to R15 raises o_R15_Write for one cycle with
//               its data on o_R15_Data (register file enable stays low).
//   undefined : R15 writes are dropped; o_R15_Write/o_R15_Data are tied to 0.
module write_back_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Freeze,
  input  logic                  i_Flush,
  input  logic                  i_Valid,
  input  logic                  i_Sig_Write_Back_Enable,
  input  logic                  i_Sig_Memory_Read,
  input  logic [REG_ADDR_W-1:0] i_Destination,
  input  logic [DATA_WIDTH-1:0] i_ALU_Result,
  input  logic [DATA_WIDTH-1:0] i_Memory_Data,
  output logic [REG_ADDR_W-1:0] o_Destination_Write_Back,
  output logic [DATA_WIDTH-1:0] o_Write_Back_Data,
  output logic                  o_Sig_Write_Back_Enable,
  output logic [DATA_WIDTH-1:0] o_Retired_Count,
  output logic                  o_R15_Write,
  output logic [DATA_WIDTH-1:0] o_R15_Data
);

  // Index with no register file entry (all ones: R15 for a 4-bit index).
  localparam logic [REG_ADDR_W-1:0] PC_REG = '1;

  logic [DATA_WIDTH-1:0] w_wb_data;
  logic                  w_valid;
  logic                  w_is_pc;
  logic                  w_pc_write;

  logic                  r_valid;
  logic                  r_wb_req;
  logic [REG_ADDR_W-1:0] r_dest;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_count;

  // Write-back source selection happens before the pipeline register.
  always_comb begin
    w_wb_data  = i_Sig_Memory_Read ? i_Memory_Data : i_ALU_Result;
    w_valid    = i_Valid & ~i_Flush;
    w_is_pc    = (i_Destination == PC_REG);
    w_pc_write = w_valid & i_Sig_Write_Back_Enable & w_is_pc;
  end

  // Pipeline register and retire counter. Flush clears the valid bit even
  // while frozen; destination/data only move on a valid capture so they
  // hold through idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_wb_req <= 1'b0;
      r_dest   <= '0;
      r_data   <= '0;
      r_count  <= '0;
    end else if (i_Freeze) begin
      if (i_Flush) begin
        r_valid  <= 1'b0;
        r_wb_req <= 1'b0;
      end
    end else begin
      r_valid  <= w_valid;
      r_wb_req <= w_valid & i_Sig_Write_Back_Enable;
      if (w_valid) begin
        r_dest  <= i_Destination;
        r_data  <= w_wb_data;
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Register file port: never enabled for invalid entries or for R15.
  always_comb begin
    o_Destination_Write_Back = r_dest;
    o_Write_Back_Data        = r_data;
    o_Sig_Write_Back_Enable  = r_valid & r_wb_req & (r_dest != PC_REG);
    o_Retired_Count          = r_count;
  end

`ifdef WB_R15_REDIRECT_EN
  logic                  r_r15_write;
  logic [DATA_WIDTH-1:0] r_r15_data;

  // R15 redirect pulse: only a fresh capture raises it, so a freeze drops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_r15_write <= 1'b0;
      r_r15_data  <= '0;
    end else if (i_Freeze) begin
      r_r15_write <= 1'b0;
    end else begin
      r_r15_write <= w_pc_write;
      if (w_pc_write) begin
        r_r15_data <= w_wb_data;
      end
    end
  end

  // Drive redirect outputs from the pulse register.
  always_comb begin
    o_R15_Write = r_r15_write;
    o_R15_Data  = r_r15_data;
  end
`else
  logic w_unused_pc_write;

  // Redirect disabled: R15 writes are dropped.
  always_comb begin
    w_unused_pc_write = w_pc_write;
    o_R15_Write       = 1'b0;
    o_R15_Data        = '0;
  end
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage: directed scenarios plus random
// traffic against a transaction-level reference model. A second, 8-bit wide
// instance sees the same traffic so the counter wrap is reachable quickly.
module tb_write_back_stage;

  logic        clk = 1'b0;
  logic        reset, freeze, flush, valid, wben, memrd;
  logic [3:0]  dest;
  logic [31:0] alu, mem;

  logic [3:0]  o_dest;
  logic [31:0] o_data, o_count, o_r15d;
  logic        o_en, o_r15w;

  logic [3:0]  n_dest;
  logic [7:0]  n_data, n_count, n_r15d;
  logic        n_en, n_r15w;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state (expected outputs after the most recent edge)
  logic [3:0]  m_dest;
  logic [31:0] m_data, m_count, m_r15d;
  logic        m_en, m_r15w;

`ifdef WB_R15_REDIRECT_EN
  localparam bit REDIRECT = 1'b1;
`else
  localparam bit REDIRECT = 1'b0;
`endif

  always #5 clk = ~clk;

  write_back_stage #(.DATA_WIDTH(32), .REG_ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .i_Freeze(freeze), .i_Flush(flush),
    .i_Valid(valid), .i_Sig_Write_Back_Enable(wben), .i_Sig_Memory_Read(memrd),
    .i_Destination(dest), .i_ALU_Result(alu), .i_Memory_Data(mem),
    .o_Destination_Write_Back(o_dest), .o_Write_Back_Data(o_data),
    .o_Sig_Write_Back_Enable(o_en), .o_Retired_Count(o_count),
    .o_R15_Write(o_r15w), .o_R15_Data(o_r15d)
  );

  write_back_stage #(.DATA_WIDTH(8), .REG_ADDR_W(4)) dut_n (
    .clk(clk), .reset(reset), .i_Freeze(freeze), .i_Flush(flush),
    .i_Valid(valid), .i_Sig_Write_Back_Enable(wben), .i_Sig_Memory_Read(memrd),
    .i_Destination(dest), .i_ALU_Result(alu[7:0]), .i_Memory_Data(mem[7:0]),
    .o_Destination_Write_Back(n_dest), .o_Write_Back_Data(n_data),
    .o_Sig_Write_Back_Enable(n_en), .o_Retired_Count(n_count),
    .o_R15_Write(n_r15w), .o_R15_Data(n_r15d)
  );

  // Apply the instruction-level rules to the inputs present at this edge.
  task automatic model_step();
    logic [31:0] d;
    bit live;
    d    = memrd ? mem : alu;
    live = valid && !flush;
    if (reset) begin
      m_dest = 0; m_data = 0; m_en = 0; m_count = 0; m_r15w = 0; m_r15d = 0;
    end else if (freeze) begin
      m_r15w = 0;                 // pulse never repeats on a held entry
      if (flush) m_en = 0;        // flush squashes even a held entry
    end else if (!live) begin
      m_en = 0; m_r15w = 0;       // idle: data/dest keep last value
    end else begin
      m_dest  = dest;
      m_data  = d;
      m_count = m_count + 1;
      m_en    = wben && (dest != 4'd15);
      m_r15w  = REDIRECT && wben && (dest == 4'd15);
      if (m_r15w) m_r15d = d;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; freeze = $urandom_range(0, 1); flush = $urandom_range(0, 1);
    valid = 1; wben = 1; memrd = 0; dest = 4'd7; alu = $urandom; mem = $urandom;
    tick(); tick();
    vectors++; if (o_dest !== 4'd0) begin miscompares++; $display("FAIL reset_dest got %0h want 0", o_dest); end
    vectors++; if (o_data !== 32'd0) begin miscompares++; $display("FAIL reset_data got %0h want 0", o_data); end
    vectors++; if (o_en !== 1'b0) begin miscompares++; $display("FAIL reset_en got %0b want 0", o_en); end
    vectors++; if (o_count !== 32'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", o_count); end
    vectors++; if (o_r15w !== 1'b0 || o_r15d !== 32'd0) begin miscompares++; $display("FAIL reset_r15 got %0b/%0h want 0/0", o_r15w, o_r15d); end
    vectors++; if (n_count !== 8'd0) begin miscompares++; $display("FAIL reset_count8 got %0d want 0", n_count); end
    freeze = 0; flush = 0;
  endtask

  task automatic test_select_and_freeze();
    reset = 0; freeze = 0; flush = 0; valid = 1; wben = 1; memrd = 0;
    dest = 4'd3; alu = 32'hDEAD_BEEF; mem = 32'h0000_1234;
    tick();
    vectors++;
    if (o_dest !== 4'd3 || o_data !== 32'hDEAD_BEEF || o_en !== 1'b1 || o_count !== 32'd1) begin
      miscompares++;
      $display("FAIL alu_select got d=%0d data=%h en=%0b cnt=%0d want d=3 data=deadbeef en=1 cnt=1", o_dest, o_data, o_en, o_count);
    end
    memrd = 1;
    tick();
    vectors++;
    if (o_dest !== 4'd3 || o_data !== 32'h0000_1234 || o_en !== 1'b1 || o_count !== 32'd2) begin
      miscompares++;
      $display("FAIL mem_select got d=%0d data=%h en=%0b cnt=%0d want d=3 data=00001234 en=1 cnt=2", o_dest, o_data, o_en, o_count);
    end
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      dest = 4'($urandom_range(0, 14)); alu = $urandom; mem = $urandom; memrd = $urandom_range(0, 1);
      tick();
      vectors++;
      if (o_dest !== 4'd3 || o_data !== 32'h0000_1234 || o_en !== 1'b1 || o_count !== 32'd2) begin
        miscompares++;
        $display("FAIL freeze_hold[%0d] got d=%0d data=%h en=%0b cnt=%0d want d=3 data=00001234 en=1 cnt=2", i, o_dest, o_data, o_en, o_count);
      end
    end
    freeze = 0; valid = 0;
    tick();
    vectors++;
    if (o_en !== 1'b0 || o_data !== 32'h0000_1234 || o_dest !== 4'd3 || o_count !== 32'd2) begin
      miscompares++;
      $display("FAIL idle_hold got d=%0d data=%h en=%0b cnt=%0d want d=3 data=00001234 en=0 cnt=2", o_dest, o_data, o_en, o_count);
    end
  endtask

  task automatic test_flush();
    logic [31:0] cnt;
    reset = 0; valid = 1; wben = 1; memrd = 0; dest = 4'd5; alu = $urandom;
    flush = 1; freeze = 0; cnt = o_count;
    tick();
    vectors++;
    if (o_en !== 1'b0 || o_count !== cnt) begin
      miscompares++; $display("FAIL flush_nofreeze got en=%0b cnt=%0d want en=0 cnt=%0d", o_en, o_count, cnt);
    end
    flush = 0; alu = 32'h0BAD_F00D;
    tick();
    cnt = cnt + 1;
    vectors++;
    if (o_en !== 1'b1 || o_count !== cnt || o_data !== 32'h0BAD_F00D) begin
      miscompares++; $display("FAIL flush_refill got en=%0b cnt=%0d data=%h want en=1 cnt=%0d data=0badf00d", o_en, o_count, o_data, cnt);
    end
    flush = 1; freeze = 1;
    tick();
    vectors++;
    if (o_en !== 1'b0 || o_count !== cnt) begin
      miscompares++; $display("FAIL flush_beats_freeze got en=%0b cnt=%0d want en=0 cnt=%0d", o_en, o_count, cnt);
    end
    flush = 0; freeze = 0;
  endtask

  task automatic test_r15();
    logic [31:0] cnt;
    reset = 0; freeze = 0; flush = 0; valid = 1; wben = 1; memrd = 0;
    dest = 4'd15; alu = 32'h0000_0100; mem = $urandom; cnt = o_count;
    tick();
    vectors++;
    if (o_en !== 1'b0 || o_count !== cnt + 1) begin
      miscompares++; $display("FAIL r15_drop got en=%0b cnt=%0d want en=0 cnt=%0d", o_en, o_count, cnt + 1);
    end
    vectors++;
    if (o_r15w !== REDIRECT || o_r15d !== (REDIRECT ? 32'h100 : 32'h0)) begin
      miscompares++; $display("FAIL r15_pulse got w=%0b d=%h want w=%0b d=%h", o_r15w, o_r15d, REDIRECT, REDIRECT ? 32'h100 : 32'h0);
    end
    freeze = 1;
    tick();
    vectors++;
    if (o_r15w !== 1'b0 || o_count !== cnt + 1) begin
      miscompares++; $display("FAIL r15_single_pulse got w=%0b cnt=%0d want w=0 cnt=%0d", o_r15w, o_count, cnt + 1);
    end
    freeze = 0; valid = 0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 39) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      valid  = ($urandom_range(0, 3) != 0);
      wben   = ($urandom_range(0, 4) != 0);
      memrd  = $urandom_range(0, 1);
      dest   = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      alu    = $urandom; mem = $urandom;
      tick();
      vectors++;
      if ({o_dest, o_data, o_en, o_count, o_r15w, o_r15d} !== {m_dest, m_data, m_en, m_count, m_r15w, m_r15d}) begin
        miscompares++;
        $display("FAIL random[%0d] got d=%0d data=%h en=%0b cnt=%0d r15=%0b/%h want d=%0d data=%h en=%0b cnt=%0d r15=%0b/%h",
                 i, o_dest, o_data, o_en, o_count, o_r15w, o_r15d, m_dest, m_data, m_en, m_count, m_r15w, m_r15d);
      end
      vectors++;
      if ({n_dest, n_data, n_en, n_count, n_r15w, n_r15d} !== {m_dest, m_data[7:0], m_en, m_count[7:0], m_r15w, m_r15d[7:0]}) begin
        miscompares++;
        $display("FAIL random8[%0d] got d=%0d data=%h en=%0b cnt=%0d r15=%0b/%h want d=%0d data=%h en=%0b cnt=%0d r15=%0b/%h",
                 i, n_dest, n_data, n_en, n_count, n_r15w, n_r15d, m_dest, m_data[7:0], m_en, m_count[7:0], m_r15w, m_r15d[7:0]);
      end
    end
    reset = 0; freeze = 0; flush = 0;
  endtask

  task automatic test_wrap();
    int unsigned budget = 0;
    reset = 0; freeze = 0; flush = 0; valid = 1; wben = 1; memrd = 0; dest = 4'd2;
    while ((m_count % 256) != 255 && budget < 300) begin
      alu = $urandom;
      tick();
      budget++;
    end
    vectors++;
    if (n_count !== 8'hFF) begin
      miscompares++; $display("FAIL wrap_preload got %0d want 255 (budget %0d)", n_count, budget);
    end
    tick();
    vectors++;
    if (n_count !== 8'h00) begin
      miscompares++; $display("FAIL wrap_to_zero got %0d want 0", n_count);
    end
    vectors++;
    if (o_count !== m_count) begin
      miscompares++; $display("FAIL wrap_wide_count got %0d want %0d", o_count, m_count);
    end
    valid = 0;
  endtask

  initial begin
    reset = 1; freeze = 0; flush = 0; valid = 0; wben = 0; memrd = 0;
    dest = '0; alu = '0; mem = '0;
    m_dest = 0; m_data = 0; m_en = 0; m_count = 0; m_r15w = 0; m_r15d = 0;
    test_reset();
    test_select_and_freeze();
    test_flush();
    test_r15();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
